// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: aligns and extends loads, replicates store data
// across byte lanes, flags address errors, tracks the LL/SC link, and runs a
// req/ack memory FSM that stalls the pipeline while a transaction is pending.
module mem_access_unit #(
    parameter int DW      = 64,
    parameter int AW      = 32,
    parameter int LLSC_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Flush,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic [1:0]      MemSize,
    input  logic            MemSignExtend,
    input  logic            LLSC,
    input  logic [AW-1:0]   Addr,
    input  logic [DW-1:0]   WriteData,
    output logic [DW-1:0]   MemReadData,
    output logic            Stall,
    output logic            AdEL,
    output logic            AdES,
    output logic            dm_req,
    output logic            dm_we,
    output logic [AW-1:0]   dm_addr,
    output logic [DW/8-1:0] dm_be,
    output logic [DW-1:0]   dm_wdata,
    input  logic [DW-1:0]   dm_rdata,
    input  logic            dm_ack,
    output logic [1:0]      StateDbg
);
    localparam int NB = DW / 8;
    localparam int LW = $clog2(NB);

    // Memory handshake: a request is presented when dm_req is high and all
    // dm_* fields stay stable until the edge where dm_ack is sampled high;
    // that edge completes the transfer and dm_rdata is only valid with it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, stateNext;

    logic [LW-1:0] reqLane;
    logic [1:0]    reqSize;
    logic          reqSign, reqLoad, reqLL, reqSC, reqFlush;
    logic          linkValid;
    logic [AW-1:3] linkAddr;

    logic          isLoad, isStore, access, misaligned;
    logic          scTry, scOk, issue, scFail, flushNow;
    int            sizeBytes;
    logic [NB-1:0] sizeMask;
    logic [NB-1:0] beNext;
    logic [DW-1:0] wdataNext;
    logic [DW-1:0] shifted, loadExt;
    logic          signBit;

    assign StateDbg = state;

    always_comb begin
        isLoad  = MemRead;
        isStore = MemWrite & ~MemRead;
        access  = (MemRead | MemWrite) & ~Flush & (state == IDLE);
        case (MemSize)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = Addr[0];
            2'd2:    misaligned = |Addr[1:0];
            default: misaligned = (DW == 32) | (|Addr[2:0]);
        endcase
        scTry    = isStore & LLSC;
        scOk     = (LLSC_EN == 0) | (linkValid & (linkAddr == Addr[AW-1:3]));
        issue    = access & ~misaligned & ~(scTry & ~scOk);
        scFail   = access & ~misaligned & scTry & ~scOk;
        flushNow = reqFlush | Flush;
        AdEL     = rst_n & access & misaligned & isLoad;
        AdES     = rst_n & access & misaligned & isStore;
        Stall    = rst_n & (issue | (state == BUSY));
    end

    // Lane shaping: byte enables and replicated store data for the new request.
    always_comb begin
        sizeBytes = 1 << MemSize;
        sizeMask  = '0;
        wdataNext = '0;
        for (int i = 0; i < NB; i++) begin
            sizeMask[i]          = (i < sizeBytes);
            wdataNext[8*i +: 8]  = WriteData[8*(i & (sizeBytes - 1)) +: 8];
        end
        beNext = sizeMask << Addr[LW-1:0];
    end

    // Load extraction uses the lane captured at issue time.
    always_comb begin
        shifted = dm_rdata >> {reqLane, 3'b000};
        case (reqSize)
            2'd0:    signBit = shifted[7];
            2'd1:    signBit = shifted[15];
            2'd2:    signBit = shifted[31];
            default: signBit = shifted[DW-1];
        endcase
        loadExt = '0;
        for (int i = 0; i < DW; i++) begin
            loadExt[i] = (i < (8 << reqSize)) ? shifted[i] : (reqSign & signBit);
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (issue) stateNext = BUSY;
            BUSY:    if (dm_ack) stateNext = flushNow ? IDLE : DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            MemReadData <= '0;
            dm_req      <= 1'b0;
            dm_we       <= 1'b0;
            dm_addr     <= '0;
            dm_be       <= '0;
            dm_wdata    <= '0;
            reqLane     <= '0;
            reqSize     <= '0;
            reqSign     <= 1'b0;
            reqLoad     <= 1'b0;
            reqLL       <= 1'b0;
            reqSC       <= 1'b0;
            reqFlush    <= 1'b0;
            linkValid   <= 1'b0;
            linkAddr    <= '0;
        end else begin
            state <= stateNext;
            if (issue) begin
                dm_req   <= 1'b1;
                dm_we    <= isStore;
                dm_addr  <= {Addr[AW-1:LW], {LW{1'b0}}};
                dm_be    <= beNext;
                dm_wdata <= wdataNext;
                reqLane  <= Addr[LW-1:0];
                reqSize  <= MemSize;
                reqSign  <= MemSignExtend;
                reqLoad  <= isLoad;
                reqLL    <= isLoad & LLSC;
                reqSC    <= scTry;
                reqFlush <= 1'b0;
                if (scTry) linkValid <= 1'b0;
            end
            if (scFail) MemReadData <= '0;
            if (state == BUSY) begin
                reqFlush <= flushNow;
                if (dm_ack) begin
                    dm_req <= 1'b0;
                    if (!flushNow && reqLoad) MemReadData <= loadExt;
                    if (!flushNow && reqSC)   MemReadData <= DW'(1);
                    if (LLSC_EN != 0) begin
                        if (!flushNow && reqLL) begin
                            linkValid <= 1'b1;
                            linkAddr  <= dm_addr[AW-1:3];
                        end
                        if (!reqLoad && !reqSC && linkAddr == dm_addr[AW-1:3])
                            linkValid <= 1'b0;
                    end
                end
            end
            // Flush always drops the link, even over a simultaneous LL completion.
            if (Flush || LLSC_EN == 0) linkValid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: 64-bit instance for the main flows and a
// 32-bit instance for the dword address-error case.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        Flush, MemRead, MemWrite, MemSignExtend, LLSC, dm_ack;
    logic [1:0]  MemSize;
    logic [31:0] Addr;
    logic [63:0] WriteData, dm_rdata;
    logic [63:0] MemReadData, dm_wdata;
    logic        Stall, AdEL, AdES, dm_req, dm_we;
    logic [31:0] dm_addr;
    logic [7:0]  dm_be;
    logic [1:0]  StateDbg;

    logic        r32, w32;
    logic [1:0]  size32;
    logic [31:0] addr32;
    logic [31:0] mrd32, wdata32;
    logic        stall32, adel32, ades32, req32, we32;
    logic [31:0] dmaddr32;
    logic [3:0]  be32;
    logic [1:0]  st32;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.DW(64), .AW(32), .LLSC_EN(1)) u64 (
        .clk(clk), .rst_n(rst_n), .Flush(Flush), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemSize(MemSize), .MemSignExtend(MemSignExtend), .LLSC(LLSC), .Addr(Addr),
        .WriteData(WriteData), .MemReadData(MemReadData), .Stall(Stall), .AdEL(AdEL),
        .AdES(AdES), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack), .StateDbg(StateDbg)
    );

    mem_access_unit #(.DW(32), .AW(32), .LLSC_EN(1)) u32 (
        .clk(clk), .rst_n(rst_n), .Flush(1'b0), .MemRead(r32), .MemWrite(w32),
        .MemSize(size32), .MemSignExtend(1'b0), .LLSC(1'b0), .Addr(addr32),
        .WriteData(32'h0), .MemReadData(mrd32), .Stall(stall32), .AdEL(adel32),
        .AdES(ades32), .dm_req(req32), .dm_we(we32), .dm_addr(dmaddr32), .dm_be(be32),
        .dm_wdata(wdata32), .dm_rdata(32'h0), .dm_ack(1'b0), .StateDbg(st32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; combinational outputs
    // are checked 1 more unit later, well before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Flush = 0; MemRead = 0; MemWrite = 0; MemSize = 0; MemSignExtend = 0;
        LLSC = 0; Addr = 0; WriteData = 0; dm_ack = 0; dm_rdata = 0;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        r32 = 0; w32 = 0; size32 = 0; addr32 = 0;
        MemRead = 1; MemSize = 2; Addr = 32'h1004;
        tick(); tick();
        #1;
        chk("rst_stall", Stall, 0);
        chk("rst_mrd", MemReadData, 0);
        chk("rst_req", dm_req, 0);
        chk("rst_be", dm_be, 0);
        chk("rst_wdata", dm_wdata, 0);
        chk("rst_state", StateDbg, 0);
        rst_n = 1;
        idle_inputs();

        // LW 0x1004 sign-extending, ack in first BUSY cycle
        tick();
        MemRead = 1; MemSize = 2; MemSignExtend = 1; Addr = 32'h1004; #1;
        chk("lw_stall0", Stall, 1);
        chk("lw_adel", AdEL, 0);
        tick();
        idle_inputs();
        dm_ack = 1; dm_rdata = 64'h80000000_00000000; #1;
        chk("lw_req", dm_req, 1);
        chk("lw_we", dm_we, 0);
        chk("lw_be", dm_be, 8'hF0);
        chk("lw_addr", dm_addr, 32'h1000);
        chk("lw_stall1", Stall, 1);
        tick();
        dm_ack = 0; #1;
        chk("lw_stall_done", Stall, 0);
        chk("lw_req_done", dm_req, 0);
        chk("lw_state_done", StateDbg, 2);
        chk("lw_data", MemReadData, 64'hFFFFFFFF_80000000);
        tick();
        #1;
        chk("lw_back_idle", StateDbg, 0);

        // SB 0x1003, ack on third BUSY cycle
        MemWrite = 1; MemSize = 0; Addr = 32'h1003; WriteData = 64'hAB; #1;
        chk("sb_stall0", Stall, 1);
        tick();
        idle_inputs(); #1;
        for (int c = 1; c <= 3; c++) begin
            chk("sb_req", dm_req, 1);
            chk("sb_we", dm_we, 1);
            chk("sb_be", dm_be, 8'h08);
            chk("sb_addr", dm_addr, 32'h1000);
            chk("sb_wdata", dm_wdata, 64'hABABABABABABABAB);
            chk("sb_stall", Stall, 1);
            if (c == 3) begin
                dm_ack = 1;
            end else begin
                tick();
                #1;
            end
        end
        tick();
        dm_ack = 0; #1;
        chk("sb_stall_done", Stall, 0);
        chk("sb_req_done", dm_req, 0);
        tick();

        // LH misaligned, and SD on the 32-bit instance
        MemRead = 1; MemSize = 1; Addr = 32'h1001;
        w32 = 1; size32 = 3; addr32 = 32'h0; #1;
        chk("lh_adel", AdEL, 1);
        chk("lh_stall", Stall, 0);
        chk("sd32_ades", ades32, 1);
        chk("sd32_stall", stall32, 0);
        tick();
        idle_inputs();
        w32 = 0; #1;
        chk("lh_noreq", dm_req, 0);
        chk("lh_state", StateDbg, 0);
        chk("sd32_noreq", req32, 0);

        // LL 0x2000 then successful SC
        MemRead = 1; LLSC = 1; MemSize = 2; Addr = 32'h2000; #1;
        chk("ll_stall", Stall, 1);
        tick();
        idle_inputs();
        dm_ack = 1; dm_rdata = 64'h00000000_12345678;
        tick();
        dm_ack = 0; #1;
        chk("ll_data", MemReadData, 64'h12345678);
        tick();
        MemWrite = 1; LLSC = 1; MemSize = 2; Addr = 32'h2000; WriteData = 64'hCAFE; #1;
        chk("sc1_stall", Stall, 1);
        tick();
        idle_inputs(); #1;
        chk("sc1_req", dm_req, 1);
        chk("sc1_be", dm_be, 8'h0F);
        chk("sc1_wdata", dm_wdata, 64'h0000CAFE_0000CAFE);
        dm_ack = 1;
        tick();
        dm_ack = 0; #1;
        chk("sc1_result", MemReadData, 1);
        tick();
        MemWrite = 1; LLSC = 1; MemSize = 2; Addr = 32'h2000; #1;
        chk("sc2_stall", Stall, 0);
        chk("sc2_ades", AdES, 0);
        tick();
        idle_inputs(); #1;
        chk("sc2_noreq", dm_req, 0);
        chk("sc2_result", MemReadData, 0);
        chk("sc2_state", StateDbg, 0);

        // LL, SW to same 8-byte granule, then SC fails
        MemRead = 1; LLSC = 1; MemSize = 2; Addr = 32'h2000;
        tick();
        idle_inputs();
        dm_ack = 1; dm_rdata = 64'h77;
        tick();
        dm_ack = 0; #1;
        chk("ll2_data", MemReadData, 64'h77);
        tick();
        MemWrite = 1; MemSize = 2; Addr = 32'h2004; WriteData = 64'h5555;
        tick();
        idle_inputs(); #1;
        chk("sw_be", dm_be, 8'hF0);
        dm_ack = 1;
        tick();
        dm_ack = 0;
        tick();
        MemWrite = 1; LLSC = 1; MemSize = 2; Addr = 32'h2000; #1;
        chk("sc3_stall", Stall, 0);
        tick();
        idle_inputs(); #1;
        chk("sc3_noreq", dm_req, 0);
        chk("sc3_result", MemReadData, 0);

        // LBU 0x3001 zero-extended, then a flushed LW
        MemRead = 1; MemSize = 0; Addr = 32'h3001;
        tick();
        idle_inputs();
        chk("lbu_be", dm_be, 8'h02);
        dm_ack = 1; dm_rdata = 64'h0000_0000_0000_A500;
        tick();
        dm_ack = 0; #1;
        chk("lbu_data", MemReadData, 64'hA5);
        tick();
        MemRead = 1; MemSize = 2; Addr = 32'h3000;
        tick();
        idle_inputs();
        Flush = 1; #1;
        chk("fl_stall1", Stall, 1);
        tick();
        Flush = 0; #1;
        chk("fl_stall2", Stall, 1);
        chk("fl_req", dm_req, 1);
        tick();
        dm_ack = 1; dm_rdata = 64'hDEAD; #1;
        chk("fl_stall3", Stall, 1);
        tick();
        dm_ack = 0; #1;
        chk("fl_state", StateDbg, 0);
        chk("fl_stall_after", Stall, 0);
        chk("fl_req_after", dm_req, 0);
        chk("fl_data_kept", MemReadData, 64'hA5);

        // Reset in BUSY, then a stale ack
        MemRead = 1; MemSize = 2; Addr = 32'h4000;
        tick();
        idle_inputs();
        rst_n = 0; #1;
        chk("rb_stall_inrst", Stall, 0);
        tick();
        #1;
        chk("rb_req", dm_req, 0);
        chk("rb_mrd", MemReadData, 0);
        rst_n = 1;
        dm_ack = 1; dm_rdata = 64'h1234;
        tick();
        dm_ack = 0; #1;
        chk("rb_state", StateDbg, 0);
        chk("rb_mrd_late", MemReadData, 0);
        chk("rb_req_late", dm_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
